// File: rtl/rv_pkg.sv
// Shared core definitions: register index width, zero register, XLEN.
// Holds the write-back match helper shared by the operand stages.
package rv_pkg;

  localparam int XLEN = 32;
  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

  function automatic logic wb_hit(
    input logic                 wen,
    input logic [REG_IDX_W-1:0] rd,
    input logic [REG_IDX_W-1:0] rs
  );
    return wen && (rd == rs) && (rs != ZERO_REG);
  endfunction

endpackage

// File: rtl/opfetch_bypass_slot.sv
// One operand slot of the R stage: index, bypass flag/value, effective operand.
// Forwarding logic is present only when OPFETCH_BYPASS_EN is defined.
module opfetch_bypass_slot
  import rv_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic                 i_hold,
  input  logic [REG_IDX_W-1:0] i_rs,
  input  logic                 i_wb_wen,
  input  logic [REG_IDX_W-1:0] i_wb_rd,
  input  logic [W-1:0]         i_wb_data,
  input  logic [W-1:0]         i_rf_data,
  output logic [REG_IDX_W-1:0] o_rs,
  output logic [W-1:0]         o_op
);

  logic [REG_IDX_W-1:0] r_rs;
  logic                 r_flag;
  logic [W-1:0]         r_val;
  logic                 w_hit_in;
  logic                 w_hit_r;

`ifdef OPFETCH_BYPASS_EN
  assign w_hit_in = wb_hit(i_wb_wen, i_wb_rd, i_rs);
  assign w_hit_r  = wb_hit(i_wb_wen, i_wb_rd, r_rs);
`else
  logic w_unused;
  assign w_unused = ^{i_wb_wen, i_wb_rd, i_wb_data, i_hold};
  assign w_hit_in = 1'b0;
  assign w_hit_r  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs   <= ZERO_REG;
      r_flag <= 1'b0;
      r_val  <= '0;
    end else if (i_load) begin
      r_rs   <= i_rs;
      r_flag <= w_hit_in;
      r_val  <= w_hit_in ? i_wb_data : '0;
    end else if (i_hold && w_hit_r) begin
      r_flag <= 1'b1;
      r_val  <= i_wb_data;
    end
  end

  // A write landing this cycle beats any older bypass or rf data
  always_comb begin
    o_op = i_rf_data;
    if (r_rs == ZERO_REG) begin
      o_op = '0;
    end else if (w_hit_r) begin
      o_op = i_wb_data;
    end else if (r_flag) begin
      o_op = r_val;
    end
  end

  assign o_rs = r_rs;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: rf read issue (R stage) and output register (O stage).
// Write-back forwarding enabled by defining OPFETCH_BYPASS_EN.
module operand_fetch
  import rv_pkg::*;
#(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int TAG_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [REG_IDX_W-1:0] dec_rs1,
  input  logic [REG_IDX_W-1:0] dec_rs2,
  input  logic [TAG_W-1:0]     dec_tag,
  output logic [REG_IDX_W-1:0] rf_r1,
  output logic [REG_IDX_W-1:0] rf_r2,
  output logic                 rf_ren,
  input  logic [XLEN-1:0]      rf_r1_data,
  input  logic [XLEN-1:0]      rf_r2_data,
  input  logic                 wb_wen,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [XLEN-1:0]      ex_op1,
  output logic [XLEN-1:0]      ex_op2,
  output logic [TAG_W-1:0]     ex_tag
);

  logic                 r_valid;
  logic [TAG_W-1:0]     r_tag;
  logic                 r_ex_valid;
  logic [XLEN-1:0]      r_ex_op1;
  logic [XLEN-1:0]      r_ex_op2;
  logic [TAG_W-1:0]     r_ex_tag;
  logic [REG_IDX_W-1:0] r_o_rs1;
  logic [REG_IDX_W-1:0] r_o_rs2;

  logic                 w_move;
  logic                 w_acc;
  logic [REG_IDX_W-1:0] w_rs1;
  logic [REG_IDX_W-1:0] w_rs2;
  logic [XLEN-1:0]      w_op1;
  logic [XLEN-1:0]      w_op2;
  logic                 w_ohit1;
  logic                 w_ohit2;

  assign w_move    = r_valid && (!r_ex_valid || ex_ready);
  assign dec_ready = !r_valid || w_move;
  assign w_acc     = dec_valid && dec_ready;
  assign rf_ren    = w_acc;
  assign rf_r1     = dec_rs1;
  assign rf_r2     = dec_rs2;

`ifdef OPFETCH_BYPASS_EN
  assign w_ohit1 = wb_hit(wb_wen, wb_rd, r_o_rs1);
  assign w_ohit2 = wb_hit(wb_wen, wb_rd, r_o_rs2);
`else
  assign w_ohit1 = 1'b0;
  assign w_ohit2 = 1'b0;
`endif

  opfetch_bypass_slot #(.W(XLEN)) u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_acc),
    .i_hold    (r_valid),
    .i_rs      (dec_rs1),
    .i_wb_wen  (wb_wen),
    .i_wb_rd   (wb_rd),
    .i_wb_data (wb_data),
    .i_rf_data (rf_r1_data),
    .o_rs      (w_rs1),
    .o_op      (w_op1)
  );

  opfetch_bypass_slot #(.W(XLEN)) u_slot2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_acc),
    .i_hold    (r_valid),
    .i_rs      (dec_rs2),
    .i_wb_wen  (wb_wen),
    .i_wb_rd   (wb_rd),
    .i_wb_data (wb_data),
    .i_rf_data (rf_r2_data),
    .o_rs      (w_rs2),
    .o_op      (w_op2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_tag   <= dec_tag;
    end else if (w_move) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
      r_ex_op1   <= '0;
      r_ex_op2   <= '0;
      r_ex_tag   <= '0;
      r_o_rs1    <= ZERO_REG;
      r_o_rs2    <= ZERO_REG;
    end else if (w_move) begin
      r_ex_valid <= 1'b1;
      r_ex_op1   <= w_op1;
      r_ex_op2   <= w_op2;
      r_ex_tag   <= r_tag;
      r_o_rs1    <= w_rs1;
      r_o_rs2    <= w_rs2;
    end else begin
      if (ex_ready) r_ex_valid <= 1'b0;
      // Stalled pair picks up late write-backs in place
      if (r_ex_valid && w_ohit1) r_ex_op1 <= wb_data;
      if (r_ex_valid && w_ohit2) r_ex_op2 <= wb_data;
    end
  end

  assign ex_valid = r_ex_valid;
  assign ex_op1   = r_ex_op1;
  assign ex_op2   = r_ex_op2;
  assign ex_tag   = r_ex_tag;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a registered-read register file model.
// Expected operands follow OPFETCH_BYPASS_EN when it is defined for the build.
module tb_operand_fetch;

  logic        clk;
  logic        rst_n;
  logic        dec_valid;
  logic        dec_ready;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [31:0] dec_tag;
  logic [4:0]  rf_r1;
  logic [4:0]  rf_r2;
  logic        rf_ren;
  logic [31:0] rf_r1_data;
  logic [31:0] rf_r2_data;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic [31:0] ex_tag;

  int n_cmp;
  int n_bad;

`ifdef OPFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic [31:0] regs [32];

  operand_fetch #(.XLEN(32), .TAG_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_rs1    (dec_rs1),
    .dec_rs2    (dec_rs2),
    .dec_tag    (dec_tag),
    .rf_r1      (rf_r1),
    .rf_r2      (rf_r2),
    .rf_ren     (rf_ren),
    .rf_r1_data (rf_r1_data),
    .rf_r2_data (rf_r2_data),
    .wb_wen     (wb_wen),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_op1     (ex_op1),
    .ex_op2     (ex_op2),
    .ex_tag     (ex_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: reads see the pre-write value on the same edge
  always @(posedge clk) begin
    if (rf_ren) begin
      rf_r1_data <= regs[rf_r1];
      rf_r2_data <= regs[rf_r2];
    end
    if (wb_wen && wb_rd != 5'd0) regs[wb_rd] <= wb_data;
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] d);
    wb_wen = 1'b1; wb_rd = rd; wb_data = d;
    @(negedge clk);
    wb_wen = 1'b0;
  endtask

  task automatic req(input logic [4:0] a, input logic [4:0] b,
                     input logic [31:0] t);
    dec_valid = 1'b1; dec_rs1 = a; dec_rs2 = b; dec_tag = t;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", ex_valid); end
    n_cmp++;
    if (ex_op1 !== 32'h0) begin n_bad++; $display("FAIL rst_op1: got %h want 0", ex_op1); end
    n_cmp++;
    if (ex_op2 !== 32'h0) begin n_bad++; $display("FAIL rst_op2: got %h want 0", ex_op2); end
    n_cmp++;
    if (ex_tag !== 32'h0) begin n_bad++; $display("FAIL rst_tag: got %h want 0", ex_tag); end
    n_cmp++;
    if (dec_ready !== 1'b1) begin n_bad++; $display("FAIL rst_dec_ready: got %b want 1", dec_ready); end
    n_cmp++;
    if (rf_ren !== 1'b0) begin n_bad++; $display("FAIL rst_rf_ren: got %b want 0", rf_ren); end
    n_cmp++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    ex_ready = 1'b1;
    req(5, 6, 32'h100);
    #1;
    chk("b2b_rf_ren", {31'd0, rf_ren}, 32'd1);
    chk("b2b_rf_r1", {27'd0, rf_r1}, 32'd5);
    @(negedge clk);
    chk("b2b_lat_valid0", {31'd0, ex_valid}, 32'd0);
    req(6, 5, 32'h101);
    #1;
    chk("b2b_ready2", {31'd0, dec_ready}, 32'd1);
    @(negedge clk);
    dec_valid = 1'b0;
    chk("b2b_v1", {31'd0, ex_valid}, 32'd1);
    chk("b2b_p1_op1", ex_op1, 32'h11);
    chk("b2b_p1_op2", ex_op2, 32'h22);
    chk("b2b_p1_tag", ex_tag, 32'h100);
    @(negedge clk);
    chk("b2b_v2", {31'd0, ex_valid}, 32'd1);
    chk("b2b_p2_op1", ex_op1, 32'h22);
    chk("b2b_p2_op2", ex_op2, 32'h11);
    chk("b2b_p2_tag", ex_tag, 32'h101);
    @(negedge clk);
    chk("b2b_drain", {31'd0, ex_valid}, 32'd0);
  endtask

  task automatic test_same_edge;
    ex_ready = 1'b1;
    req(7, 0, 32'h200);
    wb_wen = 1'b1; wb_rd = 5'd7; wb_data = 32'hABCD;
    @(negedge clk);
    dec_valid = 1'b0; wb_wen = 1'b0;
    @(negedge clk);
    chk("se_valid", {31'd0, ex_valid}, 32'd1);
    chk("se_op1", ex_op1, BYP ? 32'hABCD : 32'h7777);
    chk("se_op2", ex_op2, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_stall_forward;
    ex_ready = 1'b0;
    req(9, 5, 32'h300);
    @(negedge clk);
    dec_valid = 1'b0;
    @(negedge clk);
    chk("sf_valid", {31'd0, ex_valid}, 32'd1);
    chk("sf_op1_pre", ex_op1, 32'h9999);
    wb_wen = 1'b1; wb_rd = 5'd9; wb_data = 32'h55;
    @(negedge clk);
    wb_wen = 1'b0;
    chk("sf_op1_fwd", ex_op1, BYP ? 32'h55 : 32'h9999);
    chk("sf_op2", ex_op2, 32'h11);
    chk("sf_hold_valid", {31'd0, ex_valid}, 32'd1);
    chk("sf_hold_tag", ex_tag, 32'h300);
    ex_ready = 1'b1;
    @(negedge clk);
    chk("sf_once", {31'd0, ex_valid}, 32'd0);
  endtask

  task automatic test_x0_write;
    ex_ready = 1'b1;
    req(0, 0, 32'h400);
    wb_wen = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
    @(negedge clk);
    dec_valid = 1'b0;
    @(negedge clk);
    wb_wen = 1'b0;
    chk("x0_valid", {31'd0, ex_valid}, 32'd1);
    chk("x0_op1", ex_op1, 32'h0);
    chk("x0_op2", ex_op2, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    ex_ready = 1'b0;
    req(5, 6, 32'h500);
    #1;
    chk("bp_rdy_a", {31'd0, dec_ready}, 32'd1);
    @(negedge clk);
    req(6, 5, 32'h501);
    #1;
    chk("bp_rdy_b", {31'd0, dec_ready}, 32'd1);
    @(negedge clk);
    req(7, 9, 32'h502);
    #1;
    chk("bp_rdy_full", {31'd0, dec_ready}, 32'd0);
    chk("bp_ren_full", {31'd0, rf_ren}, 32'd0);
    chk("bp_tag_a", ex_tag, 32'h500);
    @(negedge clk);
    chk("bp_rdy_full2", {31'd0, dec_ready}, 32'd0);
    chk("bp_ren_full2", {31'd0, rf_ren}, 32'd0);
    chk("bp_tag_a2", ex_tag, 32'h500);
    chk("bp_op1_a", ex_op1, 32'h11);
    ex_ready = 1'b1;
    #1;
    chk("bp_rdy_release", {31'd0, dec_ready}, 32'd1);
    @(negedge clk);
    dec_valid = 1'b0;
    chk("bp_tag_b", ex_tag, 32'h501);
    chk("bp_b_op1", ex_op1, 32'h22);
    chk("bp_b_op2", ex_op2, 32'h11);
    @(negedge clk);
    chk("bp_tag_c", ex_tag, 32'h502);
    chk("bp_c_op1", ex_op1, 32'hABCD);
    chk("bp_c_op2", ex_op2, 32'h55);
    @(negedge clk);
    chk("bp_drain", {31'd0, ex_valid}, 32'd0);
  endtask

  task automatic test_reset_mid;
    ex_ready = 1'b0;
    req(5, 6, 32'h600);
    @(negedge clk);
    req(6, 5, 32'h601);
    @(negedge clk);
    dec_valid = 1'b0;
    chk("rm_pre_valid", {31'd0, ex_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_valid", {31'd0, ex_valid}, 32'd0);
    chk("rm_op1", ex_op1, 32'h0);
    chk("rm_op2", ex_op2, 32'h0);
    chk("rm_rdy", {31'd0, dec_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ex_ready = 1'b1;
    @(negedge clk);
    chk("rm_no_replay", {31'd0, ex_valid}, 32'd0);
    req(6, 6, 32'h700);
    @(negedge clk);
    dec_valid = 1'b0;
    @(negedge clk);
    chk("rm_new_valid", {31'd0, ex_valid}, 32'd1);
    chk("rm_new_op1", ex_op1, 32'h22);
    chk("rm_new_op2", ex_op2, 32'h22);
    chk("rm_new_tag", ex_tag, 32'h700);
    @(negedge clk);
    chk("rm_drain", {31'd0, ex_valid}, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    rf_r1_data = '0;
    rf_r2_data = '0;
    dec_valid = 1'b0;
    dec_rs1 = '0;
    dec_rs2 = '0;
    dec_tag = '0;
    wb_wen = 1'b0;
    wb_rd = '0;
    wb_data = '0;
    ex_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    wb_write(5, 32'h11);
    wb_write(6, 32'h22);
    wb_write(7, 32'h7777);
    wb_write(9, 32'h9999);
    test_back_to_back;
    test_same_edge;
    test_stall_forward;
    test_x0_write;
    test_backpressure;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
